mul_scheduler: RTL and testbench

//  Sequencer and two-port arbiter for the repeated-addition multiplier datapath (A reg, B down-counter, P accumulator).
//  Two requesters each present operands A/B; the block grants one round-robin, loads the operands over the shared

---
 rtl/mul_scheduler_if.sv | 42 ++++
 rtl/mul_scheduler.sv | 124 ++++++++++++
 tb/tb_mul_scheduler.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_scheduler_if.sv
// Bundle between the multiplier scheduler, its two requesters and the shared
// repeated-addition datapath (A register, B down-counter, P accumulator).
interface mul_scheduler_if #(
    parameter int unsigned W = 16
) ();
    // Requester port 0
    logic         req0;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic         ack0;
    logic [W-1:0] result0;
    // Requester port 1
    logic         req1;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         ack1;
    logic [W-1:0] result1;
    // Shared datapath
    logic [W-1:0] dp_data;
    logic         ld_a;
    logic         ld_b;
    logic         ld_p;
    logic         clr_p;
    logic         dec_b;
    logic         eqz;
    logic [W-1:0] prod;
    // Status
    logic         busy;
    logic         gnt_id;

    modport slave (
        input  req0, a0, b0, req1, a1, b1, eqz, prod,
        output ack0, result0, ack1, result1,
        output dp_data, ld_a, ld_b, ld_p, clr_p, dec_b, busy, gnt_id
    );

    modport master (
        output req0, a0, b0, req1, a1, b1, eqz, prod,
        input  ack0, result0, ack1, result1,
        input  dp_data, ld_a, ld_b, ld_p, clr_p, dec_b, busy, gnt_id
    );
endinterface

// File: rtl/mul_scheduler.sv
// Round-robin two-port scheduler and sequencer for the shared repeated-addition
// multiplier datapath: load A, load B / clear P, accumulate until B hits zero, return P.
module mul_scheduler #(
    parameter int unsigned W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mul_scheduler_if.slave     bus
);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StLoadB,
        StAcc,
        StResp
    } state_e;

    state_e       state_q;
    logic         gnt_q;
    logic         last_gnt_q;
    logic         ack0_q;
    logic         ack1_q;
    logic [W-1:0] result0_q;
    logic [W-1:0] result1_q;

    logic         req0_eff;
    logic         req1_eff;
    logic         win;

    logic [W-1:0] dp_data;
    logic         ld_a;
    logic         ld_b;
    logic         ld_p;
    logic         clr_p;
    logic         dec_b;

    // A port still seeing its own ack is not re-granted in that cycle.
    assign req0_eff = bus.req0 & ~ack0_q;
    assign req1_eff = bus.req1 & ~ack1_q;
    assign win      = (req0_eff & req1_eff) ? ~last_gnt_q : req1_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            result0_q  <= '0;
            result1_q  <= '0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (req0_eff | req1_eff) begin
                        gnt_q   <= win;
                        state_q <= StLoadA;
                    end
                end
                StLoadA: state_q <= StLoadB;
                StLoadB: state_q <= StAcc;
                StAcc: begin
                    if (bus.eqz) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (gnt_q) begin
                        result1_q <= bus.prod;
                        ack1_q    <= 1'b1;
                    end else begin
                        result0_q <= bus.prod;
                        ack0_q    <= 1'b1;
                    end
                    last_gnt_q <= gnt_q;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Datapath controls are decoded from the state; only ACC looks at eqz.
    always_comb begin
        dp_data = '0;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        ld_p    = 1'b0;
        clr_p   = 1'b0;
        dec_b   = 1'b0;
        unique case (state_q)
            StLoadA: begin
                ld_a    = 1'b1;
                dp_data = gnt_q ? bus.a1 : bus.a0;
            end
            StLoadB: begin
                ld_b    = 1'b1;
                clr_p   = 1'b1;
                dp_data = gnt_q ? bus.b1 : bus.b0;
            end
            StAcc: begin
                ld_p  = ~bus.eqz;
                dec_b = ~bus.eqz;
            end
            default: ;
        endcase
    end

    assign bus.dp_data = dp_data;
    assign bus.ld_a    = ld_a;
    assign bus.ld_b    = ld_b;
    assign bus.ld_p    = ld_p;
    assign bus.clr_p   = clr_p;
    assign bus.dec_b   = dec_b;
    assign bus.ack0    = ack0_q;
    assign bus.ack1    = ack1_q;
    assign bus.result0 = result0_q;
    assign bus.result1 = result1_q;
    assign bus.busy    = (state_q != StIdle);
    assign bus.gnt_id  = gnt_q;

endmodule

// File: tb/tb_mul_scheduler.sv
// Bench for mul_scheduler: behavioural datapath, directed vector table, mid-job
// reset sequence and randomized jobs checked against a cycle-timeline model.
module tb_mul_scheduler;

    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mul_scheduler_if #(.W(W)) bus ();

    mul_scheduler #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Shared datapath: A register, B down-counter, P accumulator (never reset).
    logic [W-1:0] dp_a, dp_b, dp_p;
    always_ff @(posedge clk) begin
        if (bus.ld_a) dp_a <= bus.dp_data;
        if (bus.ld_b) dp_b <= bus.dp_data;
        else if (bus.dec_b) dp_b <= dp_b - 1'b1;
        if (bus.clr_p) dp_p <= '0;
        else if (bus.ld_p) dp_p <= dp_p + dp_a;
    end
    assign bus.eqz  = (dp_b == '0);
    assign bus.prod = dp_p;

    typedef struct {
        bit           en0;
        bit           en1;
        int           d0;
        int           d1;
        logic [W-1:0] a0;
        logic [W-1:0] b0;
        logic [W-1:0] a1;
        logic [W-1:0] b1;
        int           t0;
        int           t1;
        logic [W-1:0] r0;
        logic [W-1:0] r1;
    } vec_t;

    vec_t vecs[7];
    int   tests = 0;
    int   fails = 0;

    // Model state: last granted port and held results.
    bit           m_last = 1'b1;
    logic [W-1:0] m_res0 = '0;
    logic [W-1:0] m_res1 = '0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Timeline model: a free scheduler grants at cycle t; ack lands at t+b+5, when it is free again.
    function automatic void model(input vec_t v, output vec_t o);
        int t_free;
        bit done0, done1, p0, p1, w;
        o      = v;
        o.t0   = -1;
        o.t1   = -1;
        done0  = !v.en0;
        done1  = !v.en1;
        t_free = 0;
        for (int t = 0; t < 4000 && !(done0 && done1); t++) begin
            if (t >= t_free) begin
                p0 = !done0 && t >= v.d0;
                p1 = !done1 && t >= v.d1;
                if (p0 || p1) begin
                    w = (p0 && p1) ? !m_last : p1;
                    if (w) begin
                        o.t1   = t + int'(v.b1) + 5;
                        m_res1 = W'(32'(v.a1) * 32'(v.b1));
                        done1  = 1'b1;
                        t_free = o.t1;
                    end else begin
                        o.t0   = t + int'(v.b0) + 5;
                        m_res0 = W'(32'(v.a0) * 32'(v.b0));
                        done0  = 1'b1;
                        t_free = o.t0;
                    end
                    m_last = w;
                end
            end
        end
        o.r0 = m_res0;
        o.r1 = m_res1;
    endfunction

    // Starts just after a rising edge; cycle 0 is the current cycle.
    task automatic run_vec(input vec_t v, input string tag);
        int last_t, ldp, decb, g0, g1, exp_ldp;
        last_t  = (v.t0 > v.t1) ? v.t0 : v.t1;
        ldp     = 0;
        decb    = 0;
        g0      = v.t0 - int'(v.b0) - 5;
        g1      = v.t1 - int'(v.b1) - 5;
        exp_ldp = (v.en0 ? int'(v.b0) : 0) + (v.en1 ? int'(v.b1) : 0);
        bus.a0  = v.a0;
        bus.b0  = v.b0;
        bus.a1  = v.a1;
        bus.b1  = v.b1;
        for (int c = 0; c <= last_t; c++) begin
            if (v.en0 && c == v.d0) bus.req0 = 1'b1;
            if (v.en1 && c == v.d1) bus.req1 = 1'b1;
            @(negedge clk);
            if (bus.ld_p) ldp++;
            if (bus.dec_b) decb++;
            chk($sformatf("%s ack0 c%0d", tag, c), bus.ack0, (c == v.t0));
            chk($sformatf("%s ack1 c%0d", tag, c), bus.ack1, (c == v.t1));
            if (v.en0 && c == v.t0) begin
                chk($sformatf("%s result0", tag), bus.result0, v.r0);
                chk($sformatf("%s busy@ack0", tag), bus.busy, 0);
                bus.req0 = 1'b0;
            end
            if (v.en1 && c == v.t1) begin
                chk($sformatf("%s result1", tag), bus.result1, v.r1);
                chk($sformatf("%s busy@ack1", tag), bus.busy, 0);
                bus.req1 = 1'b0;
            end
            if (v.en0 && c == g0 + 1) begin
                chk($sformatf("%s ld_a p0", tag), bus.ld_a, 1);
                chk($sformatf("%s gnt_id p0", tag), bus.gnt_id, 0);
                chk($sformatf("%s dp_data a0", tag), bus.dp_data, v.a0);
            end
            if (v.en0 && c == g0 + 2) begin
                chk($sformatf("%s ld_b/clr_p p0", tag), {bus.ld_b, bus.clr_p}, 2'b11);
                chk($sformatf("%s dp_data b0", tag), bus.dp_data, v.b0);
            end
            if (v.en1 && c == g1 + 1) begin
                chk($sformatf("%s ld_a p1", tag), bus.ld_a, 1);
                chk($sformatf("%s gnt_id p1", tag), bus.gnt_id, 1);
                chk($sformatf("%s dp_data a1", tag), bus.dp_data, v.a1);
            end
            if (v.en1 && c == g1 + 2) begin
                chk($sformatf("%s ld_b/clr_p p1", tag), {bus.ld_b, bus.clr_p}, 2'b11);
                chk($sformatf("%s dp_data b1", tag), bus.dp_data, v.b1);
            end
            @(posedge clk);
            #1;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        chk($sformatf("%s ld_p count", tag), ldp, exp_ldp);
        chk($sformatf("%s dec_b count", tag), decb, exp_ldp);
        chk($sformatf("%s hold result0", tag), bus.result0, v.r0);
        chk($sformatf("%s hold result1", tag), bus.result1, v.r1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " acks"}, {bus.ack0, bus.ack1}, 0);
        chk({tag, " results"}, {bus.result0, bus.result1}, 0);
        chk({tag, " dp ctrl"}, {bus.ld_a, bus.ld_b, bus.ld_p, bus.clr_p, bus.dec_b}, 0);
        chk({tag, " dp_data"}, bus.dp_data, 0);
        chk({tag, " gnt_id"}, bus.gnt_id, 0);
    endtask

    initial begin
        vec_t mv, rv;
        // en0 en1 d0 d1 a0 b0 a1 b1 t0 t1 r0 r1
        vecs[0] = '{1, 0, 0, 0, 17, 5, 0, 0, 10, -1, 85, 0};
        vecs[1] = '{0, 1, 0, 0, 0, 0, 9, 0, -1, 5, 85, 0};
        vecs[2] = '{1, 1, 0, 0, 3, 4, 6, 2, 9, 16, 12, 12};
        vecs[3] = '{1, 1, 0, 0, 3, 4, 6, 2, 9, 16, 12, 12};
        vecs[4] = '{1, 1, 0, 3, 7, 3, 5, 4, 8, 17, 21, 20};
        vecs[5] = '{1, 0, 0, 0, 300, 300, 0, 0, 305, -1, 24464, 20};
        vecs[6] = '{1, 0, 0, 0, 17, 5, 0, 0, 10, -1, 85, 0};

        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.a0   = '0;
        bus.b0   = '0;
        bus.a1   = '0;
        bus.b1   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            model(vecs[i], mv);
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 40; i++) begin
            rv.en0 = 1'b0;
            rv.en1 = 1'b0;
            case ($urandom_range(1, 3))
                1: rv.en0 = 1'b1;
                2: rv.en1 = 1'b1;
                default: begin rv.en0 = 1'b1; rv.en1 = 1'b1; end
            endcase
            rv.d0 = $urandom_range(0, 4);
            rv.d1 = $urandom_range(0, 4);
            rv.a0 = W'($urandom);
            rv.b0 = W'($urandom_range(0, 15));
            rv.a1 = W'($urandom);
            rv.b1 = W'($urandom_range(0, 15));
            model(rv, mv);
            run_vec(mv, $sformatf("rnd%0d", i));
        end

        // Abort a 17*5 job in ACC with an asynchronous reset.
        bus.a0   = 16'd17;
        bus.b0   = 16'd5;
        bus.req0 = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort in ACC ld_p", bus.ld_p, 1);
        rst_n = 1'b0;
        #1;
        chk_idle("abort");
        bus.req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_last = 1'b1;
        m_res0 = '0;
        m_res1 = '0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("abort no ack0 c%0d", c), bus.ack0, 0);
        end
        @(posedge clk);
        #1;
        model(vecs[6], mv);
        run_vec(vecs[6], "after_abort");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
